// File: rtl/ofs_plat_axi_stream_opaque_pkt_buf.sv
// Opaque AXI stream packet buffer: circular beat store with cut-through or
// store-and-forward release, occupancy/packet counts and oversize reporting.
module ofs_plat_axi_stream_opaque_pkt_buf #(
   parameter int TDATA_WIDTH       = 512,
   parameter int TUSER_WIDTH       = 1,
   parameter int DEPTH             = 16,
   parameter int STORE_AND_FORWARD = 0,
   localparam int NB               = (TDATA_WIDTH + 7) / 8,
   localparam int AW               = $clog2(DEPTH),
   localparam int CW               = AW + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic                   s_tlast,
   input  logic [NB-1:0]          s_tkeep,
   input  logic [NB-1:0]          s_tstrb,
   input  logic [TUSER_WIDTH-1:0] s_tuser,
   input  logic [TDATA_WIDTH-1:0] s_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   m_tlast,
   output logic [NB-1:0]          m_tkeep,
   output logic [NB-1:0]          m_tstrb,
   output logic [TUSER_WIDTH-1:0] m_tuser,
   output logic [TDATA_WIDTH-1:0] m_tdata,
   output logic [CW-1:0]          occupancy,
   output logic [CW-1:0]          pkt_count,
   output logic                   err_oversize
);

   localparam int EW = 1 + 2 * NB + TUSER_WIDTH + TDATA_WIDTH;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_occ;
   logic [CW-1:0] r_pkt;

   logic          w_push;
   logic          w_pop;
   logic          w_push_last;
   logic          w_pop_last;
   logic          w_m_tvalid;
   logic [CW-1:0] w_occ_nxt;
   logic [CW-1:0] w_pkt_nxt;

   // Ready depends on held state only; a same-cycle pop never frees a slot.
   assign s_tready    = ~reset & (r_occ != FULL);
   assign w_push      = s_tvalid & s_tready;
   assign w_pop       = w_m_tvalid & m_tready;
   assign w_push_last = w_push & s_tlast;
   assign w_pop_last  = w_pop & m_tlast;

   always_comb begin
      w_occ_nxt = r_occ + CW'(w_push) - CW'(w_pop);
      w_pkt_nxt = r_pkt + CW'(w_push_last) - CW'(w_pop_last);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_pkt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_occ <= w_occ_nxt;
         r_pkt <= w_pkt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {s_tlast, s_tkeep, s_tstrb, s_tuser, s_tdata};
      end
   end

   assign {m_tlast, m_tkeep, m_tstrb, m_tuser, m_tdata} = r_mem[r_rd_ptr];

   assign m_tvalid  = w_m_tvalid;
   assign occupancy = r_occ;
   assign pkt_count = r_pkt;

   if (STORE_AND_FORWARD != 0) begin : g_sf
      typedef enum logic {
         ST_HOLD = 1'b0,
         ST_SEND = 1'b1
      } st_e;

      st_e  r_state;
      st_e  w_state_nxt;
      logic w_force;
      logic r_err;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_state <= ST_HOLD;
            r_err   <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_err   <= w_force;
         end
      end

      // Decide on post-update counts so release starts the cycle after the last push.
      always_comb begin
         w_state_nxt = r_state;
         w_force     = 1'b0;
         unique case (r_state)
            ST_HOLD: begin
               if (w_pkt_nxt != '0) begin
                  w_state_nxt = ST_SEND;
               end else if (w_occ_nxt == FULL) begin
                  w_state_nxt = ST_SEND;
                  w_force     = 1'b1;
               end
            end
            ST_SEND: begin
               if (w_pop_last && (w_pkt_nxt == '0)) begin
                  w_state_nxt = ST_HOLD;
               end
            end
            default: w_state_nxt = ST_HOLD;
         endcase
      end

      always_comb begin
         w_m_tvalid   = (r_state == ST_SEND) && (r_occ != '0);
         err_oversize = r_err;
      end
   end else begin : g_ct
      always_comb begin
         w_m_tvalid   = (r_occ != '0);
         err_oversize = 1'b0;
      end
   end

endmodule

// File: tb/tb_ofs_plat_axi_stream_opaque_pkt_buf.sv
// Bench for the opaque packet buffer: three configurations checked against a
// queue-based model every cycle, plus directed scenarios with literal values.
module tb_ofs_plat_axi_stream_opaque_pkt_buf;

   typedef struct packed {
      logic        last;
      logic [1:0]  keep;
      logic [1:0]  strb;
      logic        user;
      logic [15:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        s_tvalid [3];
   logic        s_tlast  [3];
   logic [1:0]  s_tkeep  [3];
   logic [1:0]  s_tstrb  [3];
   logic        s_tuser  [3];
   logic [15:0] s_tdata  [3];
   logic        m_tready [3];

   logic        s_tready [3];
   logic        m_tvalid [3];
   logic        m_tlast  [3];
   logic [1:0]  m_tkeep  [3];
   logic [1:0]  m_tstrb  [3];
   logic        m_tuser  [3];
   logic [15:0] m_tdata  [3];
   logic [3:0]  occ      [3];
   logic [3:0]  pkt      [3];
   logic        err      [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // 0: cut-through depth 4, 1: store-and-forward depth 8, 2: store-and-forward depth 4
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int D  = (g == 1) ? 8 : 4;
      localparam int SF = (g == 0) ? 0 : 1;
      localparam int W  = $clog2(D) + 1;
      logic [W-1:0] occ_w;
      logic [W-1:0] pkt_w;

      ofs_plat_axi_stream_opaque_pkt_buf #(
         .TDATA_WIDTH(16),
         .TUSER_WIDTH(1),
         .DEPTH(D),
         .STORE_AND_FORWARD(SF)
      ) u_dut (
         .clk(clk),
         .reset(reset),
         .s_tvalid(s_tvalid[g]),
         .s_tready(s_tready[g]),
         .s_tlast(s_tlast[g]),
         .s_tkeep(s_tkeep[g]),
         .s_tstrb(s_tstrb[g]),
         .s_tuser(s_tuser[g]),
         .s_tdata(s_tdata[g]),
         .m_tvalid(m_tvalid[g]),
         .m_tready(m_tready[g]),
         .m_tlast(m_tlast[g]),
         .m_tkeep(m_tkeep[g]),
         .m_tstrb(m_tstrb[g]),
         .m_tuser(m_tuser[g]),
         .m_tdata(m_tdata[g]),
         .occupancy(occ_w),
         .pkt_count(pkt_w),
         .err_oversize(err[g])
      );

      assign occ[g] = 4'(occ_w);
      assign pkt[g] = 4'(pkt_w);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: queue of beats, packets counted as stored lasts.
   beat_t mq [3][$];
   bit    forced  [3];
   bit    err_exp [3];

   function automatic int depth_of(int k);
      return (k == 1) ? 8 : 4;
   endfunction

   function automatic bit sf_of(int k);
      return k != 0;
   endfunction

   function automatic int lasts(int k);
      int n = 0;
      foreach (mq[k][i]) if (mq[k][i].last) n++;
      return n;
   endfunction

   function automatic bit exp_valid(int k);
      return (mq[k].size() != 0) &&
             (!sf_of(k) || forced[k] || (lasts(k) > 0));
   endfunction

   function automatic bit exp_ready(int k);
      return !reset && (mq[k].size() < depth_of(k));
   endfunction

   always @(posedge clk) begin : model
      beat_t b;
      bit    pu;
      bit    po;
      for (int k = 0; k < 3; k++) begin
         err_exp[k] = 1'b0;
         if (reset) begin
            mq[k].delete();
            forced[k] = 1'b0;
         end else begin
            pu = s_tvalid[k] && exp_ready(k);
            po = exp_valid(k) && m_tready[k];
            if (po) begin
               b = mq[k].pop_front();
               if (b.last) forced[k] = 1'b0;
            end
            if (pu) begin
               b = {s_tlast[k], s_tkeep[k], s_tstrb[k], s_tuser[k], s_tdata[k]};
               mq[k].push_back(b);
            end
            if (sf_of(k) && !forced[k] && mq[k].size() == depth_of(k) &&
                lasts(k) == 0) begin
               forced[k]  = 1'b1;
               err_exp[k] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin : cmp
      beat_t b;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("k%0d_s_tready", k), 32'(s_tready[k]), 32'(exp_ready(k)));
         chk($sformatf("k%0d_m_tvalid", k), 32'(m_tvalid[k]), 32'(exp_valid(k)));
         chk($sformatf("k%0d_occupancy", k), 32'(occ[k]), 32'(mq[k].size()));
         chk($sformatf("k%0d_pkt_count", k), 32'(pkt[k]), 32'(lasts(k)));
         chk($sformatf("k%0d_err", k), 32'(err[k]), 32'(err_exp[k]));
         if (exp_valid(k)) begin
            b = mq[k][0];
            chk($sformatf("k%0d_m_tdata", k), 32'(m_tdata[k]), 32'(b.data));
            chk($sformatf("k%0d_m_tlast", k), 32'(m_tlast[k]), 32'(b.last));
            chk($sformatf("k%0d_m_tkeep", k), 32'(m_tkeep[k]), 32'(b.keep));
            chk($sformatf("k%0d_m_tstrb", k), 32'(m_tstrb[k]), 32'(b.strb));
            chk($sformatf("k%0d_m_tuser", k), 32'(m_tuser[k]), 32'(b.user));
         end
      end
   end

   logic [15:0] pop_log [$];
   int          nerr = 0;

   always @(negedge clk) begin
      if (m_tvalid[2] === 1'b1 && m_tready[2] === 1'b1) pop_log.push_back(m_tdata[2]);
      if (err[2] === 1'b1) nerr++;
   end

   function automatic beat_t mk(input logic [15:0] d, input logic l);
      beat_t b;
      b.last = l;
      b.keep = d[5:4];
      b.strb = d[7:6];
      b.user = d[8];
      b.data = d;
      return b;
   endfunction

   task automatic drv(input int k, input logic v, input beat_t b);
      s_tvalid[k] = v;
      s_tlast[k]  = b.last;
      s_tkeep[k]  = b.keep;
      s_tstrb[k]  = b.strb;
      s_tuser[k]  = b.user;
      s_tdata[k]  = b.data;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic push(input int k, input beat_t b);
      int n   = 0;
      bit acc = 1'b0;
      drv(k, 1'b1, b);
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = s_tready[k];
         tick();
         n++;
      end
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL push_timeout k=%0d got ready=0 required ready=1", k);
      end
      drv(k, 1'b0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got no finish required finish by 200000");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         drv(k, 1'b0, '0);
         m_tready[k] = 1'b0;
      end
      reset = 1'b1;
      repeat (2) @(posedge clk);
      neg();
      chk("rst_s_tready", 32'(s_tready[0]), 32'd0);
      chk("rst_occ", 32'(occ[1]), 32'd0);
      chk("rst_m_tvalid", 32'(m_tvalid[1]), 32'd0);
      chk("rst_err", 32'(err[2]), 32'd0);
      tick();
      reset = 1'b0;
      neg();
      chk("rel_s_tready", 32'(s_tready[0]), 32'd1);

      // 1: cut-through ordering
      m_tready[0] = 1'b1;
      tick();
      drv(0, 1'b1, mk(16'h1234, 1'b0));
      tick();
      drv(0, 1'b1, mk(16'h5678, 1'b0));
      neg();
      chk("t1_v0", 32'(m_tvalid[0]), 32'd1);
      chk("t1_d0", 32'(m_tdata[0]), 32'h1234);
      chk("t1_l0", 32'(m_tlast[0]), 32'd0);
      tick();
      drv(0, 1'b1, mk(16'h9ABC, 1'b1));
      neg();
      chk("t1_d1", 32'(m_tdata[0]), 32'h5678);
      tick();
      drv(0, 1'b0, '0);
      neg();
      chk("t1_d2", 32'(m_tdata[0]), 32'h9ABC);
      chk("t1_l2", 32'(m_tlast[0]), 32'd1);
      tick();
      neg();
      chk("t1_occ", 32'(occ[0]), 32'd0);
      chk("t1_v", 32'(m_tvalid[0]), 32'd0);

      // 2: fill to full with sink stalled
      tick();
      m_tready[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drv(0, 1'b1, mk(16'h2100 + 16'(i), 1'b0));
         tick();
      end
      drv(0, 1'b1, mk(16'h2104, 1'b1));
      neg();
      chk("t2_full_rdy", 32'(s_tready[0]), 32'd0);
      chk("t2_full_occ", 32'(occ[0]), 32'd4);
      chk("t2_head", 32'(m_tdata[0]), 32'h2100);
      tick();
      m_tready[0] = 1'b1;
      neg();
      chk("t2_held_occ", 32'(occ[0]), 32'd4);
      tick();
      neg();
      chk("t2_pop1_occ", 32'(occ[0]), 32'd3);
      chk("t2_pop1_rdy", 32'(s_tready[0]), 32'd1);
      chk("t2_pop1_d", 32'(m_tdata[0]), 32'h2101);
      tick();
      drv(0, 1'b0, '0);
      neg();
      chk("t2_acc_occ", 32'(occ[0]), 32'd3);
      chk("t2_acc_pkt", 32'(pkt[0]), 32'd1);
      tick();
      tick();
      neg();
      chk("t2_5th_d", 32'(m_tdata[0]), 32'h2104);
      chk("t2_5th_l", 32'(m_tlast[0]), 32'd1);
      tick();
      neg();
      chk("t2_end_occ", 32'(occ[0]), 32'd0);

      // 5: simultaneous push/pop of lasts across pointer wrap
      tick();
      for (int i = 0; i < 3; i++) begin
         drv(0, 1'b1, mk(16'h5A00 + 16'(i), 1'b1));
         tick();
      end
      drv(0, 1'b0, '0);
      tick();
      tick();
      m_tready[0] = 1'b0;
      drv(0, 1'b1, mk(16'h5F00, 1'b1));
      tick();
      drv(0, 1'b1, mk(16'h5F01, 1'b0));
      tick();
      drv(0, 1'b1, mk(16'h5F02, 1'b1));
      m_tready[0] = 1'b1;
      neg();
      chk("t5_occ_a", 32'(occ[0]), 32'd2);
      chk("t5_pkt_a", 32'(pkt[0]), 32'd1);
      chk("t5_d0", 32'(m_tdata[0]), 32'h5F00);
      tick();
      neg();
      chk("t5_occ_b", 32'(occ[0]), 32'd2);
      chk("t5_pkt_b", 32'(pkt[0]), 32'd1);
      chk("t5_d1", 32'(m_tdata[0]), 32'h5F01);
      drv(0, 1'b1, mk(16'h5F03, 1'b1));
      tick();
      drv(0, 1'b0, '0);
      neg();
      chk("t5_pkt_c", 32'(pkt[0]), 32'd2);
      chk("t5_d2", 32'(m_tdata[0]), 32'h5F02);
      tick();
      neg();
      chk("t5_d3", 32'(m_tdata[0]), 32'h5F03);
      tick();
      neg();
      chk("t5_end_occ", 32'(occ[0]), 32'd0);

      // 3: store-and-forward holds until last beat stored
      m_tready[1] = 1'b1;
      tick();
      drv(1, 1'b1, mk(16'h3310, 1'b0));
      tick();
      drv(1, 1'b0, '0);
      neg();
      chk("t3_hold0", 32'(m_tvalid[1]), 32'd0);
      tick();
      drv(1, 1'b1, mk(16'h3321, 1'b0));
      tick();
      drv(1, 1'b0, '0);
      neg();
      chk("t3_hold1", 32'(m_tvalid[1]), 32'd0);
      chk("t3_occ2", 32'(occ[1]), 32'd2);
      tick();
      drv(1, 1'b1, mk(16'h33F2, 1'b1));
      tick();
      drv(1, 1'b0, '0);
      neg();
      chk("t3_rel_v", 32'(m_tvalid[1]), 32'd1);
      chk("t3_rel_pkt", 32'(pkt[1]), 32'd1);
      chk("t3_d0", 32'(m_tdata[1]), 32'h3310);
      tick();
      neg();
      chk("t3_d1", 32'(m_tdata[1]), 32'h3321);
      tick();
      neg();
      chk("t3_d2", 32'(m_tdata[1]), 32'h33F2);
      chk("t3_l2", 32'(m_tlast[1]), 32'd1);
      tick();
      neg();
      chk("t3_end_v", 32'(m_tvalid[1]), 32'd0);
      chk("t3_end_pkt", 32'(pkt[1]), 32'd0);

      // 4: oversize packet forces release
      tick();
      m_tready[2] = 1'b1;
      for (int i = 0; i < 6; i++) push(2, mk(16'h4000 + 16'(i), i == 5));
      repeat (6) tick();
      neg();
      chk("t4_npops", 32'(pop_log.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < pop_log.size()) chk($sformatf("t4_pop%0d", i), 32'(pop_log[i]), 32'h4000 + 32'(i));
      end
      chk("t4_nerr", 32'(nerr), 32'd1);
      chk("t4_occ", 32'(occ[2]), 32'd0);
      tick();
      drv(2, 1'b1, mk(16'h4A00, 1'b0));
      tick();
      drv(2, 1'b0, '0);
      neg();
      chk("t4_hold_v", 32'(m_tvalid[2]), 32'd0);
      chk("t4_hold_occ", 32'(occ[2]), 32'd1);

      // 6: reset mid-packet
      tick();
      m_tready[0] = 1'b0;
      drv(0, 1'b1, mk(16'h6000, 1'b1));
      tick();
      drv(0, 1'b1, mk(16'h6001, 1'b0));
      tick();
      drv(0, 1'b1, mk(16'h6002, 1'b0));
      tick();
      drv(0, 1'b1, mk(16'h6003, 1'b0));
      reset = 1'b1;
      neg();
      chk("t6_pre_occ", 32'(occ[0]), 32'd3);
      chk("t6_rst_rdy", 32'(s_tready[0]), 32'd0);
      tick();
      reset = 1'b0;
      drv(0, 1'b1, mk(16'h6100, 1'b0));
      m_tready[0] = 1'b1;
      neg();
      chk("t6_occ", 32'(occ[0]), 32'd0);
      chk("t6_pkt", 32'(pkt[0]), 32'd0);
      chk("t6_v", 32'(m_tvalid[0]), 32'd0);
      chk("t6_rdy", 32'(s_tready[0]), 32'd1);
      chk("t6_k2_occ", 32'(occ[2]), 32'd0);
      tick();
      drv(0, 1'b1, mk(16'h61F1, 1'b1));
      neg();
      chk("t6_d0", 32'(m_tdata[0]), 32'h6100);
      chk("t6_l0", 32'(m_tlast[0]), 32'd0);
      tick();
      drv(0, 1'b0, '0);
      neg();
      chk("t6_d1", 32'(m_tdata[0]), 32'h61F1);
      chk("t6_l1", 32'(m_tlast[0]), 32'd1);
      chk("t6_pkt1", 32'(pkt[0]), 32'd1);
      tick();
      neg();
      chk("t6_end_occ", 32'(occ[0]), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
